// File: rtl/nibbler_io_pkg.sv
// Shared definitions for the Nibbler I/O blocks: nibble width, nibble type and
// the default debounce length used by the button input port.
package nibbler_io_pkg;
    localparam int NIBBLE_W = 4;
    typedef logic [NIBBLE_W-1:0] nibble_t;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
endpackage

// File: rtl/nibbler_debounce_bit.sv
// One pushbutton channel: two-flop synchronizer, mismatch counter, stable level
// flop, and a one-cycle rise pulse on the edge where stable commits 0->1.
module nibbler_debounce_bit
    import nibbler_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);
    // Smallest width holding DEBOUNCE_CYCLES-1; the count never exceeds it.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;
    logic             commit;

    assign commit = (sync2 != stable) && (count == CNT_LAST);
    assign rise   = commit && sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                count <= '0;
            end else if (commit) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/nibbler_button_input.sv
// Debounced 4-button input port for the Nibbler CPU. Sticky press flags are
// built only when NIBBLER_BUTTON_EVENT_LATCH_EN is defined; otherwise they read 0.
module nibbler_button_input
    import nibbler_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic    clk,
    input  logic    reset,
    input  nibble_t rawButtons,
    input  logic    readStrobe,
    output nibble_t buttons,
    output nibble_t pressEvents,
    output logic    eventPending
);
    nibble_t rise;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        nibbler_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (rawButtons[i]),
            .stable(buttons[i]),
            .rise  (rise[i])
        );
    end

`ifdef NIBBLER_BUTTON_EVENT_LATCH_EN
    nibble_t events;

    // A press committing on the same edge as a CPU read survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            events <= '0;
        end else begin
            events <= (readStrobe ? '0 : events) | rise;
        end
    end

    assign pressEvents  = events;
    assign eventPending = |events;
`else
    logic unused_event_inputs;
    assign unused_event_inputs = ^{readStrobe, rise};

    assign pressEvents  = '0;
    assign eventPending = 1'b0;
`endif
endmodule
